// File: rtl/conv_code_pkg.sv
// Shared K=7 convolutional code definitions for the encoder and the viterbi decoder.
// Holds code constants, the soft symbol type, the encoder FSM states and the tap parity helper.
package conv_code_pkg;

  localparam int K       = 7;
  localparam int STATE_W = 6;

  localparam logic [K-1:0] G1_DEF = 7'b1111001;
  localparam logic [K-1:0] G2_DEF = 7'b1011011;

  typedef logic signed [7:0] soft_t;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    TAIL,
    DRAIN,
    DONE
  } enc_state_t;

  function automatic logic parity7(
    input logic [K-1:0] r7,
    input logic [K-1:0] g
  );
    return ^(r7 & g);
  endfunction

endpackage

// File: rtl/soft_sym_buf.sv
// Two-entry soft symbol serializer: loads a {first, second} pair and presents them in order.
// Ports: clk, sys_rst, load, sym_a/sym_b (pair), soft_out/valid_out/ready_out (stream), empty.
module soft_sym_buf
  import conv_code_pkg::*;
(
  input  logic  clk,
  input  logic  sys_rst,
  input  logic  load,
  input  soft_t sym_a,
  input  soft_t sym_b,
  output soft_t soft_out,
  output logic  valid_out,
  input  logic  ready_out,
  output logic  empty
);

  logic [1:0] cnt;
  soft_t      second;

  // load is only issued while empty, so it never collides with a pop
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt      <= 2'd0;
      soft_out <= '0;
      second   <= '0;
    end else if (load) begin
      cnt      <= 2'd2;
      soft_out <= sym_a;
      second   <= sym_b;
    end else if (valid_out && ready_out) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd2) begin
        soft_out <= second;
      end
    end
  end

  assign valid_out = (cnt != 2'd0);
  assign empty     = (cnt == 2'd0);

endmodule

// File: rtl/conv_encoder_k7.sv
// Rate-1/2 K=7 convolutional encoder with 6-bit zero tail and signed soft symbol output.
// Ports: start/bit_in/valid_in/ready_in (input), soft_out/valid_out/ready_out, busy, frame_done, last_state.
module conv_encoder_k7
  import conv_code_pkg::*;
#(
  parameter int           FRAME_BITS = 1024,
  parameter logic [K-1:0] G1         = G1_DEF,
  parameter logic [K-1:0] G2         = G2_DEF,
  parameter soft_t        SOFT_AMP   = 8'sd127,
  parameter logic         INV_G2     = 1'b0
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               bit_in,
  input  logic               valid_in,
  output logic               ready_in,
  output soft_t              soft_out,
  output logic               valid_out,
  input  logic               ready_out,
  output logic               busy,
  output logic               frame_done,
  output logic [STATE_W-1:0] last_state
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam soft_t NEG_AMP = -SOFT_AMP;

  enc_state_t         state;
  enc_state_t         state_nxt;
  logic [STATE_W-1:0] sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [2:0]         tail_cnt;
  logic               empty;
  logic               take;
  logic               load;
  logic               enc_bit;
  logic [K-1:0]       r7;
  logic               c1;
  logic               c2;
  soft_t              sym_a;
  soft_t              sym_b;

  assign ready_in = (state == DATA) && empty;
  assign take     = valid_in && ready_in;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    enc_bit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = DATA;
      end
      DATA: begin
        if (take) begin
          load    = 1'b1;
          enc_bit = bit_in;
          if (bit_cnt == LAST_BIT) state_nxt = TAIL;
        end
      end
      // tail bits are zeros injected whenever the buffer frees up
      TAIL: begin
        if (empty) begin
          load = 1'b1;
          if (tail_cnt == 3'd5) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign r7    = {enc_bit, sr};
  assign c1    = parity7(r7, G1);
  assign c2    = parity7(r7, G2) ^ INV_G2;
  assign sym_a = c1 ? NEG_AMP : SOFT_AMP;
  assign sym_b = c2 ? NEG_AMP : SOFT_AMP;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      tail_cnt   <= 3'd0;
      frame_done <= 1'b0;
      last_state <= '0;
    end else begin
      frame_done <= (state == DRAIN) && empty;
      if ((state == DRAIN) && empty) begin
        last_state <= sr;
      end
      if ((state == IDLE) && start) begin
        sr       <= '0;
        bit_cnt  <= '0;
        tail_cnt <= 3'd0;
      end
      if (load) begin
        sr <= {enc_bit, sr[STATE_W-1:1]};
      end
      if (take) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if ((state == TAIL) && empty) begin
        tail_cnt <= (tail_cnt == 3'd5) ? 3'd0 : tail_cnt + 3'd1;
      end
    end
  end

  soft_sym_buf u_buf (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .load      (load),
    .sym_a     (sym_a),
    .sym_b     (sym_b),
    .soft_out  (soft_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .empty     (empty)
  );

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Self-checking bench for conv_encoder_k7: table vectors, reset/backpressure sequences,
// and random payloads against a convolution reference model.
module tb_conv_encoder_k7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              st [3];
  logic              bi [3];
  logic              vi [3];
  logic              ro [3];
  logic              ri [3];
  logic              vo [3];
  logic              bz [3];
  logic              fd [3];
  logic signed [7:0] so [3];
  logic [5:0]        ls [3];

  conv_encoder_k7 #(.FRAME_BITS(8)) u0 (
    .clk(clk), .sys_rst(rst), .start(st[0]), .bit_in(bi[0]),
    .valid_in(vi[0]), .ready_in(ri[0]), .soft_out(so[0]),
    .valid_out(vo[0]), .ready_out(ro[0]), .busy(bz[0]),
    .frame_done(fd[0]), .last_state(ls[0])
  );

  conv_encoder_k7 #(.FRAME_BITS(1024), .SOFT_AMP(8'sd64)) u1 (
    .clk(clk), .sys_rst(rst), .start(st[1]), .bit_in(bi[1]),
    .valid_in(vi[1]), .ready_in(ri[1]), .soft_out(so[1]),
    .valid_out(vo[1]), .ready_out(ro[1]), .busy(bz[1]),
    .frame_done(fd[1]), .last_state(ls[1])
  );

  conv_encoder_k7 #(.FRAME_BITS(5), .SOFT_AMP(8'sd1), .INV_G2(1'b1)) u2 (
    .clk(clk), .sys_rst(rst), .start(st[2]), .bit_in(bi[2]),
    .valid_in(vi[2]), .ready_in(ri[2]), .soft_out(so[2]),
    .valid_out(vo[2]), .ready_out(ro[2]), .busy(bz[2]),
    .frame_done(fd[2]), .last_state(ls[2])
  );

  typedef struct {
    logic [7:0]  pl;
    int          stall;
    bit          spam;
    logic [13:0] c1e;
    logic [13:0] c2e;
  } vec_t;

  vec_t tbl [4];

  int npass = 0;
  int ntot  = 0;
  int got0 [$];
  int got1 [$];
  int got2 [$];
  int expq [$];
  bit pay  [$];
  int done_cnt [3];
  bit fin [3];
  logic pv [3];
  logic pr [3];
  logic signed [7:0] ps [3];
  logic [6:0] g1m = 7'b1111001;
  logic [6:0] g2m = 7'b1011011;

  task automatic chk(input string nm, input int act, input int req);
    ntot++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic push_got(input int d, input int v);
    case (d)
      0: got0.push_back(v);
      1: got1.push_back(v);
      default: got2.push_back(v);
    endcase
  endtask

  function automatic int got_size(input int d);
    case (d)
      0: return got0.size();
      1: return got1.size();
      default: return got2.size();
    endcase
  endfunction

  function automatic int got_at(input int d, input int i);
    case (d)
      0: return got0[i];
      1: return got1[i];
      default: return got2[i];
    endcase
  endfunction

  task automatic clr_got(input int d);
    case (d)
      0: got0.delete();
      1: got1.delete();
      default: got2.delete();
    endcase
  endtask

  // output monitor: stall stability, handshake capture, frame_done count
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        if (fd[d]) done_cnt[d]++;
        if (pv[d] && !pr[d]) begin
          chk("hold_valid", int'(vo[d]), 1);
          chk("hold_soft", int'(so[d]), int'(ps[d]));
          chk("stall_ready_in", int'(ri[d]), 0);
        end
        if (vo[d] && ro[d]) push_got(d, int'(so[d]));
      end
      pv[d] = vo[d];
      pr[d] = ro[d];
      ps[d] = so[d];
    end
  end

  // symbols from the code definition: each output is a tap-weighted parity
  // over the last 7 input bits of (payload followed by six zeros)
  task automatic model_fill(input int n, input int amp, input bit inv);
    bit a;
    bit b;
    bit x;
    int p;
    expq.delete();
    for (int t = 0; t < n + 6; t++) begin
      a = 1'b0;
      b = 1'b0;
      for (int j = 0; j < 7; j++) begin
        p = t - j;
        x = (p >= 0 && p < n) ? pay[p] : 1'b0;
        a ^= x & g1m[6-j];
        b ^= x & g2m[6-j];
      end
      b ^= inv;
      expq.push_back(a ? -amp : amp);
      expq.push_back(b ? -amp : amp);
    end
  endtask

  task automatic table_fill(input vec_t v);
    pay.delete();
    expq.delete();
    for (int i = 0; i < 8; i++) pay.push_back(v.pl[i]);
    for (int t = 0; t < 14; t++) begin
      expq.push_back(v.c1e[t] ? -127 : 127);
      expq.push_back(v.c2e[t] ? -127 : 127);
    end
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_ready_in"}, int'(ri[d]), 0);
    chk({tag, "_valid_out"}, int'(vo[d]), 0);
    chk({tag, "_soft_out"}, int'(so[d]), 0);
    chk({tag, "_busy"}, int'(bz[d]), 0);
    chk({tag, "_frame_done"}, int'(fd[d]), 0);
    chk({tag, "_last_state"}, int'(ls[d]), 0);
  endtask

  task automatic run(input int d, input int n, input int stall_at,
                     input bit spam, input bit rnd, input string tag);
    int tail_rdy;
    bit to;
    int mm;
    int lim;
    clr_got(d);
    done_cnt[d] = 0;
    fin[d] = 1'b0;
    tail_rdy = 0;
    to = 1'b0;
    @(posedge clk); #1 st[d] = 1'b1;
    @(posedge clk); #1 st[d] = 1'b0;
    fork
      begin : feeder
        int idx;
        int cyc;
        bit hs;
        idx = 0;
        cyc = 0;
        bi[d] = pay[0];
        vi[d] = 1'b1;
        while (idx < n && cyc < n * 10 + 100) begin
          @(negedge clk);
          hs = ri[d];
          @(posedge clk); #1;
          if (hs) begin
            idx++;
            if (idx < n) bi[d] = pay[idx];
          end
          cyc++;
        end
        if (idx < n) to = 1'b1;
        bi[d] = 1'b1;
        while (done_cnt[d] == 0 && cyc < n * 10 + 400) begin
          @(negedge clk);
          if (ri[d]) tail_rdy++;
          cyc++;
        end
        if (done_cnt[d] == 0) to = 1'b1;
        vi[d] = 1'b0;
        fin[d] = 1'b1;
      end
      begin : driver
        int c;
        c = 0;
        while (!fin[d]) begin
          @(posedge clk); #1;
          c++;
          if (rnd) ro[d] = ($urandom_range(3) != 0);
          else ro[d] = !(stall_at >= 0 && c >= stall_at && c < stall_at + 5);
          st[d] = spam && (c == 5 || c == 36);
        end
        st[d] = 1'b0;
        ro[d] = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    mm = 0;
    lim = (got_size(d) < expq.size()) ? got_size(d) : expq.size();
    for (int i = 0; i < lim; i++) if (got_at(d, i) != expq[i]) mm++;
    chk({tag, "_timeout"}, int'(to), 0);
    chk({tag, "_sym_count"}, got_size(d), 2 * (n + 6));
    chk({tag, "_stream_mismatches"}, mm, 0);
    chk({tag, "_frame_done_pulses"}, done_cnt[d], 1);
    chk({tag, "_last_state"}, int'(ls[d]), 0);
    chk({tag, "_tail_ready_in"}, tail_rdy, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int cyc;
    tbl[0] = '{8'h00, -1, 1'b0, 14'b00000000000000, 14'b00000000000000};
    tbl[1] = '{8'h01, -1, 1'b0, 14'b00000001001111, 14'b00000001101101};
    tbl[2] = '{8'hFF, 10, 1'b1, 14'b11101011000101, 14'b10010011011011};
    tbl[3] = '{8'h01, 4, 1'b0, 14'b00000001001111, 14'b00000001101101};
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0;
      bi[d] = 1'b0;
      vi[d] = 1'b0;
      ro[d] = 1'b1;
      done_cnt[d] = 0;
      fin[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset(0, "init");

    for (int v = 0; v < 4; v++) begin
      table_fill(tbl[v]);
      run(0, 8, tbl[v].stall, tbl[v].spam, 1'b0, $sformatf("vec%0d", v));
    end

    // reset in the middle of DATA after three accepted bits
    table_fill(tbl[1]);
    done_cnt[0] = 0;
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    vi[0] = 1'b1;
    acc = 0;
    cyc = 0;
    bi[0] = pay[0];
    while (acc < 3 && cyc < 50) begin
      @(negedge clk);
      if (ri[0]) begin
        @(posedge clk); #1;
        acc++;
        bi[0] = pay[acc];
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    chk("midrst_accepted", acc, 3);
    chk("midrst_busy_before", int'(bz[0]), 1);
    rst = 1'b1;
    vi[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset(0, "midrst");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt[0], 0);
    run(0, 8, -1, 1'b0, 1'b0, "post_rst");

    pay.delete();
    for (int i = 0; i < 1024; i++) pay.push_back(1'($urandom_range(1)));
    model_fill(1024, 64, 1'b0);
    run(1, 1024, -1, 1'b0, 1'b1, "rand1024");

    for (int f = 0; f < 2; f++) begin
      pay.delete();
      for (int i = 0; i < 5; i++) pay.push_back(1'($urandom_range(1)));
      model_fill(5, 1, 1'b1);
      run(2, 5, -1, 1'b0, 1'b1, $sformatf("inv%0d", f));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
